// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a handshaked word-wide data memory.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | waiting for req_valid; the accepting cycle stalls the pipeline
// BUSY  | memory transaction outstanding, mem_req held until mem_ack
// DONE  | one-cycle completion pulse; pipeline advances, no new accept
module lsu_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_mode,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [2:0]  mode_q;
  logic [1:0]  lane_q;

  logic        req_byte, req_half, req_misal;
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n;
  logic        ld_byte, ld_half, ld_signed;
  logic [31:0] shifted, ext;

  always_comb begin
    req_byte = (req_mode == 3'b001) || (req_mode == 3'b010);
    req_half = (req_mode == 3'b011) || (req_mode == 3'b100);
    wstrb_n  = 4'b1111;
    wdata_n  = req_wdata;
    if (req_byte) begin
      wstrb_n = 4'b0001 << req_addr[1:0];
      wdata_n = {4{req_wdata[7:0]}};
    end else if (req_half) begin
      wstrb_n = 4'b0011 << {req_addr[1], 1'b0};
      wdata_n = {2{req_wdata[15:0]}};
    end
    if (!req_we) wstrb_n = 4'b0000;
`ifdef LSU_MISALIGN_TRAP_EN
    req_misal = (req_half && req_addr[0]) ||
                (!req_byte && !req_half && (req_addr[1:0] != 2'b00));
`else
    req_misal = 1'b0;
`endif
  end

  // Load lane selection uses the mode/lane captured at accept time.
  always_comb begin
    ld_byte   = (mode_q == 3'b001) || (mode_q == 3'b010);
    ld_half   = (mode_q == 3'b011) || (mode_q == 3'b100);
    ld_signed = (mode_q == 3'b001) || (mode_q == 3'b011);
    shifted   = mem_rdata;
    ext       = mem_rdata;
    if (ld_byte) begin
      shifted = mem_rdata >> {lane_q, 3'b000};
      ext     = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
    end else if (ld_half) begin
      shifted = mem_rdata >> {lane_q[1], 4'b0000};
      ext     = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
    end
  end

  assign stall = !rst && (((state == IDLE) && req_valid) || (state == BUSY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'h0;
      rdata     <= 32'h0;
      done      <= 1'b0;
      misalign  <= 1'b0;
      mode_q    <= 3'b000;
      lane_q    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          misalign <= 1'b0;
          if (req_valid) begin
            if (req_misal) begin
              state    <= DONE;
              done     <= 1'b1;
              misalign <= 1'b1;
            end else begin
              state     <= BUSY;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wstrb <= wstrb_n;
              mem_wdata <= wdata_n;
              mode_q    <= req_mode;
              lane_q    <= req_addr[1:0];
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state     <= DONE;
            done      <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            if (!mem_we) rdata <= ext;
          end
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          misalign <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized accesses
// compared against an arithmetic byte-lane model of the load/store rules.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_mode;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] rdata;
  logic        done, misalign;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_mode(req_mode),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rdata(rdata), .done(done), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] exp_rdata = 32'h0;
  int          done_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int unsigned acc_size(input logic [2:0] m);
    if (m == 3'd1 || m == 3'd2) return 1;
    if (m == 3'd3 || m == 3'd4) return 2;
    return 4;
  endfunction

  function automatic int unsigned lane_off(input logic [2:0] m, input logic [31:0] a);
    int unsigned sz = acc_size(m);
    if (sz == 1) return a % 4;
    if (sz == 2) return (a % 4) & 2;
    return 0;
  endfunction

  function automatic bit is_misaligned(input logic [2:0] m, input logic [31:0] a);
    int unsigned sz = acc_size(m);
    return (sz > 1) && ((a % sz) != 0);
  endfunction

  function automatic logic [3:0] strb_model(input logic [2:0] m, input logic [31:0] a);
    int unsigned sz = acc_size(m);
    int unsigned v = ((1 << sz) - 1) << lane_off(m, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] wdata_model(input logic [2:0] m, input logic [31:0] w);
    int unsigned sz = acc_size(m);
    if (sz == 1) return (w & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] load_model(input logic [2:0] m, input logic [31:0] a,
                                             input logic [31:0] w);
    int unsigned sz = acc_size(m);
    logic [31:0] mask, v;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v = (w >> (8 * lane_off(m, a))) & mask;
    if ((m == 3'd1 || m == 3'd3) && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // Entered just after a rising edge with the DUT idle; leaves just after a rising edge.
  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] mode, input int nwait, input logic [31:0] rword);
    bit trap;
    int req_cnt, stall_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = is_misaligned(mode, addr);
`else
    trap = 1'b0;
`endif
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_mode = mode;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("accept_stall", stall, 1);
    chk("accept_no_req", mem_req, 0);
    chk("accept_done", done, 0);
    @(posedge clk); #1;
    if (trap) begin
      @(negedge clk);
      chk("trap_done", done, 1);
      chk("trap_misalign", misalign, 1);
      chk("trap_no_req", mem_req, 0);
      chk("trap_stall", stall, 0);
      chk("trap_rdata", rdata, exp_rdata);
    end else begin
      req_cnt = 0;
      stall_cnt = 1;
      for (int k = 0; k <= nwait; k++) begin
        @(negedge clk);
        if (mem_req) req_cnt++;
        if (stall) stall_cnt++;
        chk("busy_done", done, 0);
        if (k == 0) begin
          chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
          chk("mem_we", mem_we, we);
          chk("mem_wstrb", mem_wstrb, we ? strb_model(mode, addr) : 4'b0000);
          if (we) chk("mem_wdata", mem_wdata, wdata_model(mode, wdata));
        end
        mem_ack   = (k == nwait);
        mem_rdata = (k == nwait) ? rword : $urandom;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      chk("req_cycles", req_cnt, nwait + 1);
      chk("stall_cycles", stall_cnt, nwait + 2);
      if (!we) exp_rdata = load_model(mode, addr, rword);
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("done_no_req", mem_req, 0);
      chk("done_we", mem_we, 0);
      chk("done_wstrb", mem_wstrb, 0);
      chk("done_stall", stall, 0);
      chk("done_misalign", misalign, 0);
      chk("done_rdata", rdata, exp_rdata);
    end
    done_cyc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    int d0;
    logic [31:0] w;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h13; req_wdata = 32'h0;
    req_mode = 3'd0; mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk); @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", done, 0);
    chk("rst_misalign", misalign, 0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_access(1'b0, 32'h13, 32'h0, 3'd1, 0, 32'h80FF7F01);
    chk("lb_signed", rdata, 32'hFFFF_FF80);
    do_access(1'b0, 32'h13, 32'h0, 3'd2, 1, 32'h80FF7F01);
    chk("lb_unsigned", rdata, 32'h0000_0080);
    do_access(1'b1, 32'h22, 32'h0000BEEF, 3'd3, 0, 32'h1234_5678);
    chk("sh_keeps_rdata", rdata, 32'h0000_0080);
    w = $urandom;
    do_access(1'b0, 32'h100, 32'h0, 3'd0, 4, w);
    chk("lw_wait", rdata, w);
    do_access(1'b0, 32'h06, 32'h0, 3'd0, 0, 32'hCAFE_F00D);

    // Reset in the second BUSY cycle of a load
    do_access(1'b0, 32'h40, 32'h0, 3'd0, 0, 32'h5A5A_1234);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h44; req_mode = 3'd0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_req", mem_req, 1);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_req", mem_req, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_done", done, 0);
    exp_rdata = 32'h0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_ack_stall", stall, 0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_done", done, 0);
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_rdata", rdata, 0);
    @(posedge clk); #1;
    do_access(1'b0, 32'h45, 32'h0, 3'd1, 2, 32'h00F0_0000);

    // Back-to-back zero-wait loads
    do_access(1'b0, 32'h200, 32'h0, 3'd4, 0, $urandom);
    d0 = done_cyc;
    do_access(1'b0, 32'h302, 32'h0, 3'd3, 0, $urandom);
    chk("b2b_spacing", done_cyc - d0, 3);

    for (int i = 0; i < 60; i++) begin
      do_access(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
                $urandom_range(0, 3), $urandom);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        @(negedge clk);
        chk("gap_stall", stall, 0);
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
